// File: rtl/pc_gen_pkg.sv
// Shared types and width helpers for the program-counter generator and its BTB.
// The BTB (pc_btb) exists only when PC_GEN_BTB_EN is defined.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Widest PC the BTB entry layout can hold; tag and target are zero-extended into it.
    localparam int unsigned PC_W_MAX = 32;

    typedef struct packed {
        logic                valid;
        logic [PC_W_MAX-1:0] tag;
        logic [PC_W_MAX-1:0] target;
    } btb_entry_t;

    function automatic int unsigned btb_off_w(input int unsigned step);
        return $clog2(step);
    endfunction

    function automatic int unsigned btb_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned btb_tag_w(input int unsigned pc_w,
                                              input int unsigned step,
                                              input int unsigned depth);
        return pc_w - btb_off_w(step) - btb_idx_w(depth);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake, redirect and BTB-update bundle between the CPU front end and pc_gen.
interface pc_gen_if #(
    parameter int unsigned PC_W = 32
);
    logic            fetch_ready_i;
    logic            data_suspend_i;
    logic            flush_i;
    logic [PC_W-1:0] npc_i;
    logic            trap_i;
    logic [PC_W-1:0] trap_pc_i;
    logic            halt_i;
    logic            btb_upd_i;
    logic [PC_W-1:0] btb_upd_pc_i;
    logic [PC_W-1:0] btb_upd_target_i;
    logic            btb_upd_taken_i;
    logic [PC_W-1:0] pc_o;
    logic            fetch_valid_o;
    logic            pred_taken_o;
    logic [PC_W-1:0] pred_target_o;

    modport slave (
        input  fetch_ready_i, data_suspend_i, flush_i, npc_i, trap_i, trap_pc_i, halt_i,
        input  btb_upd_i, btb_upd_pc_i, btb_upd_target_i, btb_upd_taken_i,
        output pc_o, fetch_valid_o, pred_taken_o, pred_target_o
    );

    modport master (
        output fetch_ready_i, data_suspend_i, flush_i, npc_i, trap_i, trap_pc_i, halt_i,
        output btb_upd_i, btb_upd_pc_i, btb_upd_target_i, btb_upd_taken_i,
        input  pc_o, fetch_valid_o, pred_taken_o, pred_target_o
    );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one update port written at the edge.
// Instantiated by pc_gen only when PC_GEN_BTB_EN is defined.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned STEP      = 4,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [PC_W-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic [PC_W-1:0] target_o,
    input  logic            upd_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_taken_i
);
    localparam int unsigned OFF_W = btb_off_w(STEP);
    localparam int unsigned IDX_W = btb_idx_w(BTB_DEPTH);
    localparam int unsigned TAG_W = btb_tag_w(PC_W, STEP, BTB_DEPTH);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(STEP - 1);

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       btb_rd [BTB_DEPTH];
    btb_entry_t       lk_entry;

    assign lk_idx  = IDX_W'(lookup_pc_i >> OFF_W);
    assign lk_tag  = TAG_W'(lookup_pc_i >> (OFF_W + IDX_W));
    assign upd_idx = IDX_W'(upd_pc_i >> OFF_W);
    assign upd_tag = TAG_W'(upd_pc_i >> (OFF_W + IDX_W));

    genvar gi;
    generate
        for (gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
            btb_entry_t entry_d;
            btb_entry_t entry_q;

            always_comb begin
                entry_d = entry_q;
                if (upd_i && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken_i) begin
                        entry_d.valid  = 1'b1;
                        entry_d.tag    = PC_W_MAX'(upd_tag);
                        entry_d.target = PC_W_MAX'(upd_target_i & ALIGN_MASK);
                    end else if (entry_q.tag == PC_W_MAX'(upd_tag)) begin
                        // A not-taken resolution only evicts the branch it names, never an alias.
                        entry_d.valid = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign btb_rd[gi] = entry_q;
        end
    endgenerate

    // Lookup reads the registered entries, so a same-cycle update is seen only next cycle.
    assign lk_entry = btb_rd[lk_idx];
    assign hit_o    = lk_entry.valid && (lk_entry.tag == PC_W_MAX'(lk_tag));
    assign target_o = hit_o ? PC_W'(lk_entry.target) : '0;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT FSM, PC register and prioritised next-PC mux.
// Define PC_GEN_BTB_EN to add the branch target buffer (pc_btb) for taken-branch prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] INIT_PC   = 32'hFFFF_FFFC,
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     BTB_DEPTH = 16
) (
    input logic      clk_i,
    input logic      reset_i,
    pc_gen_if.slave  bus
);
    localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(STEP - 1);

    pc_state_e       state_d, state_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            fetch_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;

    function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

`ifdef PC_GEN_BTB_EN
    pc_btb #(
        .PC_W      (PC_W),
        .STEP      (STEP),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .lookup_pc_i  (pc_q),
        .hit_o        (pred_taken),
        .target_o     (pred_target),
        .upd_i        (bus.btb_upd_i),
        .upd_pc_i     (bus.btb_upd_pc_i),
        .upd_target_i (bus.btb_upd_target_i),
        .upd_taken_i  (bus.btb_upd_taken_i)
    );
`else
    logic unused_btb_upd;

    assign pred_taken     = 1'b0;
    assign pred_target    = '0;
    assign unused_btb_upd = ^{bus.btb_upd_i, bus.btb_upd_pc_i,
                              bus.btb_upd_target_i, bus.btb_upd_taken_i};
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_valid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (bus.trap_i) begin
                    pc_d = align(bus.trap_pc_i);
                end else if (bus.flush_i) begin
                    pc_d = align(bus.npc_i);
                end else begin
                    pc_d = pc_q + STEP_V;
                end
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (bus.trap_i) begin
                    pc_d = align(bus.trap_pc_i);
                end else if (bus.flush_i) begin
                    pc_d = align(bus.npc_i);
                end else if (bus.data_suspend_i || !bus.fetch_ready_i) begin
                    pc_d = pc_q;
                end else if (bus.halt_i) begin
                    // The current PC has been accepted; park on it until a redirect.
                    state_d = HALT;
                end else if (pred_taken) begin
                    pc_d = align(pred_target);
                end else begin
                    pc_d = pc_q + STEP_V;
                end
            end
            HALT: begin
                if (bus.trap_i) begin
                    pc_d    = align(bus.trap_pc_i);
                    state_d = RUN;
                end else if (bus.flush_i) begin
                    pc_d    = align(bus.npc_i);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = INIT_PC;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= BOOT;
            pc_q    <= INIT_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = fetch_valid;
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
// Works with or without PC_GEN_BTB_EN.
module tb_pc_gen;
    localparam int DEPTH = 16;
    localparam bit BTB_ON =
`ifdef PC_GEN_BTB_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model: 0 = BOOT, 1 = RUN, 2 = HALT
    logic [31:0] m_pc;
    int          m_state;
    bit          m_bv   [DEPTH];
    logic [31:0] m_bkey [DEPTH];
    logic [31:0] m_btgt [DEPTH];

    pc_gen_if #(.PC_W(32)) bus ();

    pc_gen #(
        .PC_W      (32),
        .INIT_PC   (32'hFFFF_FFFC),
        .STEP      (4),
        .BTB_DEPTH (DEPTH)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'hFFFF_FFFC;
        m_state = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_bv[i]   = 1'b0;
            m_bkey[i] = '0;
            m_btgt[i] = '0;
        end
    endtask

    task automatic set_idle();
        bus.fetch_ready_i    = 1'b1;
        bus.data_suspend_i   = 1'b0;
        bus.flush_i          = 1'b0;
        bus.npc_i            = '0;
        bus.trap_i           = 1'b0;
        bus.trap_pc_i        = '0;
        bus.halt_i           = 1'b0;
        bus.btb_upd_i        = 1'b0;
        bus.btb_upd_pc_i     = '0;
        bus.btb_upd_target_i = '0;
        bus.btb_upd_taken_i  = 1'b0;
    endtask

    // Compare outputs with the model, advance the model by one clock, return at the next negedge.
    task automatic step();
        int          idx;
        bit          hit;
        logic [31:0] tgt;
        logic [31:0] key;
        idx = int'((m_pc >> 2) % DEPTH);
        hit = BTB_ON && m_bv[idx] && (m_bkey[idx] == (m_pc >> 2));
        tgt = hit ? m_btgt[idx] : 32'h0;
        chk("pc_o", bus.pc_o, m_pc);
        chk("fetch_valid_o", {31'b0, bus.fetch_valid_o}, {31'b0, m_state == 1});
        chk("pred_taken_o", {31'b0, bus.pred_taken_o}, {31'b0, hit});
        chk("pred_target_o", bus.pred_target_o, tgt);

        if (m_state == 0) begin
            m_state = 1;
            if (bus.trap_i) m_pc = bus.trap_pc_i & ~32'h3;
            else if (bus.flush_i) m_pc = bus.npc_i & ~32'h3;
            else m_pc = m_pc + 32'd4;
        end else if (m_state == 1) begin
            if (bus.trap_i) m_pc = bus.trap_pc_i & ~32'h3;
            else if (bus.flush_i) m_pc = bus.npc_i & ~32'h3;
            else if (bus.data_suspend_i || !bus.fetch_ready_i) m_pc = m_pc;
            else if (bus.halt_i) m_state = 2;
            else if (hit) m_pc = tgt;
            else m_pc = m_pc + 32'd4;
        end else begin
            if (bus.trap_i) begin
                m_pc = bus.trap_pc_i & ~32'h3;
                m_state = 1;
            end else if (bus.flush_i) begin
                m_pc = bus.npc_i & ~32'h3;
                m_state = 1;
            end
        end

        if (BTB_ON && bus.btb_upd_i) begin
            key = bus.btb_upd_pc_i >> 2;
            idx = int'(key % DEPTH);
            if (bus.btb_upd_taken_i) begin
                m_bv[idx]   = 1'b1;
                m_bkey[idx] = key;
                m_btgt[idx] = bus.btb_upd_target_i & ~32'h3;
            end else if (m_bkey[idx] == key) begin
                m_bv[idx] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_to(input logic [31:0] target);
        bus.flush_i = 1'b1;
        bus.npc_i   = target;
        step();
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Boot sequence
        chk("boot_valid", {31'b0, bus.fetch_valid_o}, 32'h0);
        chk("boot_pc", bus.pc_o, 32'hFFFF_FFFC);
        step();
        chk("first_pc", bus.pc_o, 32'h0000_0000);
        step();
        chk("second_pc", bus.pc_o, 32'h0000_0004);
        step();
        chk("third_pc", bus.pc_o, 32'h0000_0008);
        step();
        step();
        chk("reach_10", bus.pc_o, 32'h0000_0010);

        // Suspend then suspend+flush
        bus.data_suspend_i = 1'b1;
        step();
        chk("suspend_hold", bus.pc_o, 32'h0000_0010);
        bus.flush_i = 1'b1;
        bus.npc_i   = 32'h200;
        step();
        set_idle();
        chk("flush_over_suspend", bus.pc_o, 32'h0000_0200);

        // Trap beats flush; misaligned flush target
        bus.trap_i    = 1'b1;
        bus.trap_pc_i = 32'h8000_0000;
        bus.flush_i   = 1'b1;
        bus.npc_i     = 32'h40;
        step();
        set_idle();
        chk("trap_over_flush", bus.pc_o, 32'h8000_0000);
        flush_to(32'h43);
        chk("flush_aligned", bus.pc_o, 32'h0000_0040);

        // Halt
        flush_to(32'h20);
        bus.halt_i = 1'b1;
        step();
        bus.halt_i = 1'b0;
        chk("halt_valid", {31'b0, bus.fetch_valid_o}, 32'h0);
        chk("halt_pc", bus.pc_o, 32'h0000_0020);
        repeat (5) step();
        chk("halt_still_pc", bus.pc_o, 32'h0000_0020);
        flush_to(32'h100);
        chk("unhalt_pc", bus.pc_o, 32'h0000_0100);
        chk("unhalt_valid", {31'b0, bus.fetch_valid_o}, 32'h1);

        // BTB train, predict, evict, alias
        bus.btb_upd_i        = 1'b1;
        bus.btb_upd_pc_i     = 32'h30;
        bus.btb_upd_taken_i  = 1'b1;
        bus.btb_upd_target_i = 32'h80;
        flush_to(32'h28);
        step();
        step();
        chk("at_30", bus.pc_o, 32'h0000_0030);
        chk("pred_30", {31'b0, bus.pred_taken_o}, BTB_ON ? 32'h1 : 32'h0);
        step();
        chk("after_30", bus.pc_o, BTB_ON ? 32'h0000_0080 : 32'h0000_0034);
        bus.btb_upd_i       = 1'b1;
        bus.btb_upd_pc_i    = 32'h30;
        bus.btb_upd_taken_i = 1'b0;
        flush_to(32'h30);
        chk("evicted_pred", {31'b0, bus.pred_taken_o}, 32'h0);
        step();
        chk("evicted_next", bus.pc_o, 32'h0000_0034);
        bus.btb_upd_i        = 1'b1;
        bus.btb_upd_pc_i     = 32'h30;
        bus.btb_upd_taken_i  = 1'b1;
        bus.btb_upd_target_i = 32'h80;
        flush_to(32'h70);
        chk("alias_pred", {31'b0, bus.pred_taken_o}, 32'h0);
        step();
        chk("alias_next", bus.pc_o, 32'h0000_0074);
        flush_to(32'h30);
        chk("retrained_pred", {31'b0, bus.pred_taken_o}, BTB_ON ? 32'h1 : 32'h0);

        // Asynchronous reset mid-run
        flush_to(32'h1234);
        chk("at_1234", bus.pc_o, 32'h0000_1234);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.pc_o, 32'hFFFF_FFFC);
        chk("async_rst_valid", {31'b0, bus.fetch_valid_o}, 32'h0);
        chk("async_rst_pred", {31'b0, bus.pred_taken_o}, 32'h0);
        chk("async_rst_tgt", bus.pred_target_o, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        flush_to(32'h30);
        chk("post_rst_pc", bus.pc_o, 32'h0000_0030);
        chk("post_rst_pred", {31'b0, bus.pred_taken_o}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.fetch_ready_i    = ($urandom_range(0, 7) != 0);
            bus.data_suspend_i   = ($urandom_range(0, 7) == 0);
            bus.flush_i          = ($urandom_range(0, 15) == 0);
            bus.npc_i            = 32'($urandom_range(0, 32'h1FF));
            bus.trap_i           = ($urandom_range(0, 31) == 0);
            bus.trap_pc_i        = $urandom;
            bus.halt_i           = ($urandom_range(0, 31) == 0);
            bus.btb_upd_i        = (m_state == 1) && ($urandom_range(0, 3) == 0);
            bus.btb_upd_pc_i     = 32'($urandom_range(0, 127)) << 2;
            bus.btb_upd_target_i = 32'($urandom_range(0, 127)) << 2;
            bus.btb_upd_taken_i  = ($urandom_range(0, 2) != 0);
            step();
        end
        set_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU front end. It holds the fetch PC and advances it by a fixed step under a valid/ready fetch handshake. It applies trap and branch-flush redirects with fixed priority and supports a halt state. An optional direct-mapped branch target buffer (BTB) predicts taken-branch targets. It sits at the head of IF and feeds the instruction-memory address and the IF/ID register.

## Interface
- PC_W, 32, PC width in bits
- INIT_PC, 32'hFFFF_FFFC, reset value of pc_o; the first step lands on INIT_PC+STEP (0x0000_0000)
- STEP, 4, sequential increment in bytes; power of two
- BTB_DEPTH, 16, BTB entries; power of two, at least 2

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- fetch_ready_i  in  1  IF consumer accepts the current PC
- data_suspend_i  in  1  load-use stall; hold PC
- flush_i  in  1  branch/jump resolved mispredicted; redirect to npc_i
- npc_i  in  PC_W  flush target
- trap_i  in  1  exception/interrupt; redirect to trap_pc_i
- trap_pc_i  in  PC_W  trap vector
- halt_i  in  1  enter HALT after the current PC
- btb_upd_i  in  1  BTB update strobe from EX
- btb_upd_pc_i  in  PC_W  PC of the resolved branch
- btb_upd_target_i  in  PC_W  resolved target
- btb_upd_taken_i  in  1  branch taken
- pc_o  out  PC_W  current fetch PC
- fetch_valid_o  out  1  pc_o is a valid fetch request
- pred_taken_o  out  1  BTB hit on pc_o; next PC is pred_target_o
- pred_target_o  out  PC_W  predicted target; 0 when no hit

## Operation
- FSM states: BOOT, RUN, HALT. Reset sets state to BOOT, pc_o to INIT_PC, and clears all BTB valid bits.
- BOOT lasts exactly one cycle with fetch_valid_o=0, then goes to RUN. In that cycle pc_o steps to INIT_PC+STEP unless trap_i or flush_i redirects it. This gives the first instruction a full cycle after reset is released.
- RUN: fetch_valid_o=1. Next-PC selection, highest priority first:
  - trap_i: trap_pc_i
  - flush_i: npc_i
  - data_suspend_i or !fetch_ready_i: hold
  - halt_i: hold, and go to HALT
  - pred_taken_o: pred_target_o
  - otherwise: pc_o+STEP
- HALT: fetch_valid_o=0 and PC held. trap_i or flush_i loads the target and returns to RUN. Other inputs are ignored.
- The low log2(STEP) bits of every loaded target are forced to 0.
- Arithmetic: pc_o+STEP wraps modulo 2^PC_W (0xFFFF_FFFC -> 0x0000_0000), with no flag.
- BTB entry fields: valid, tag (PC bits PC_W-1 down to log2(STEP)+log2(BTB_DEPTH)), target. Index is PC bits log2(STEP)+log2(BTB_DEPTH)-1 down to log2(STEP).
- BTB lookup is combinational on pc_o. A hit requires valid and a tag match.
- BTB update on btb_upd_i:
  - taken: write valid, tag and target (allocate or overwrite)
  - not taken: clear valid if the tag matches, otherwise no change
- Flush and trap do not alter BTB contents.

## Timing
- Redirects, steps and state changes take effect on the next rising clk_i edge: one-cycle redirect latency.
- BTB update is written at the clock edge and is visible to lookup from the following cycle. If an update and a lookup hit the same index in the same cycle, the lookup sees the old contents.
- flush_i together with data_suspend_i: flush wins.
- trap_i together with flush_i: trap wins.
- halt_i together with a redirect: the redirect wins, state stays RUN, halt is dropped.
- reset_i asserted mid-operation: outputs return immediately and asynchronously to their reset values: pc_o=INIT_PC, fetch_valid_o=0, pred_taken_o=0, pred_target_o=0.

## Configuration
- PC_GEN_BTB_EN defined: the BTB is instantiated and prediction works as described above.
- PC_GEN_BTB_EN undefined: there is no BTB storage. pred_taken_o=0 and pred_target_o=0 always, and the btb_upd_* ports are accepted and ignored. Sequential selection then falls straight to pc_o+STEP.

## Structure
- Shared package pc_gen_pkg holds:
  - the state enum (BOOT, RUN, HALT)
  - the BTB entry struct
  - helper functions for index and tag widths derived from STEP and BTB_DEPTH
- One sub-module, pc_btb: storage, combinational lookup and update port, parameterised by PC_W, STEP and BTB_DEPTH. It is instantiated only under PC_GEN_BTB_EN.
- pc_gen keeps the FSM, the PC register and the next-PC priority mux.

## Test plan
- Reset release, fetch_ready_i=1, no other events:
  - fetch_valid_o=0 for the BOOT cycle
  - pc_o sequence is 0xFFFF_FFFC, 0x0, 0x4, 0x8
- At pc_o=0x10, assert data_suspend_i for 2 cycles, with flush_i (npc_i=0x200) in the second cycle: pc_o holds 0x10 for one cycle, then becomes 0x200.
- trap_i (trap_pc_i=0x8000_0000) and flush_i (npc_i=0x40) in the same cycle: pc_o becomes 0x8000_0000. Misaligned npc_i=0x43 on a flush gives pc_o=0x40.
- halt_i at pc_o=0x20:
  - fetch_valid_o drops and pc_o holds 0x20 while 5 cycles of steps are ignored
  - flush_i with npc_i=0x100 returns to RUN with pc_o=0x100
- With PC_GEN_BTB_EN: update pc=0x30, taken, target=0x80, then fetch reaches 0x30:
  - pred_taken_o=1 and the next pc_o is 0x80
  - a not-taken update for 0x30 clears the entry, and the next visit steps to 0x34
  - aliasing pc 0x70 (same index, different tag) gives no hit
- Assert reset_i asynchronously mid-run at pc_o=0x1234: pc_o=0xFFFF_FFFC before the next clock edge, and all BTB entries read invalid afterwards.
